wordle_guess_ctrl: RTL and testbench
====================================

# wordle_guess_ctrl

Sequencing controller for one Wordle game. It sits between the keyboard block's letter/key pulses and the VGA board renderer. It collects up to five letters per row and handles backspace and enter. On enter it scores the guess against the latched target word with a fixed-latency two-pass (green, then yellow) scan that handles duplicate letters correctly. It then advances through six rows and ends in WIN or LOSE until acknowledged.

## Interface
Parameters:
- `ROWS`, default 6: number of guesses allowed.
- `LET_W`, default 5: letter code width. Code 0 = A … 25 = Z; codes 26–31 are illegal.

Ports:
- `Clk`, in, 1: system clock; single clock domain.
- `reset`, in, 1: synchronous, active-low reset.
- `Start`, in, 1: one-cycle pulse (debouncer SCEN); starts a game from IDLE.
- `Ack`, in, 1: one-cycle pulse; leaves WIN/LOSE.
- `target`, in, 25: target word. Position p is `target[5p+4:5p]`; position 0 is the leftmost letter.
- `letter_en`, in, 1: one-cycle pulse; a letter key was pressed.
- `letter`, in, 5: letter code; sampled when `letter_en`=1.
- `bksp`, in, 1: one-cycle pulse; delete the last letter.
- `enter`, in, 1: one-cycle pulse; submit the row.
- `guess_word`, out, 25: letters of the current row, same packing as `target`; unfilled positions read 0.
- `row`, out, 3: current row, 0..ROWS-1.
- `col`, out, 3: number of letters entered, 0..5.
- `score`, out, 10: result for the last scored row. Position p is `score[2p+1:2p]`: 00 empty, 01 gray, 10 yellow, 11 green.
- `score_valid`, out, 1: one-cycle pulse when `score` and `score_row` are updated.
- `score_row`, out, 3: row that `score` belongs to.
- `q_I`, `q_Entry`, `q_Green`, `q_Yellow`, `q_Commit`, `q_Win`, `q_Lose`, out, 1 each: one-hot state flags.

## Operation
- **IDLE.** On `Start`: latch `target` into an internal register, clear `row`, `col`, `guess_word` and `score`, and go to ENTRY. Other inputs are ignored.
- **ENTRY.** At most one key event is acted on per cycle, with priority `enter` > `bksp` > `letter_en`. Lower-priority events in the same cycle are dropped.
  - `letter_en`: if `col`<5 and `letter`≤25, write the letter at position `col` and increment `col`. Otherwise ignore it.
  - `bksp`: if `col`>0, decrement `col` and zero that position. Otherwise ignore it.
  - `enter`: if `col`==5, go to GREEN. Otherwise ignore it.
- **GREEN.** Runs exactly 5 cycles, with index i = 0..4.
  - If guess[i]==tgt[i], mark result[i]=11 and set used[i] and matched[i].
  - Otherwise mark result[i]=01.
  - Then go to YELLOW.
- **YELLOW.** Runs exactly 25 cycles over (i,j), with i outer 0..4 and j inner 0..4.
  - When !matched[i] && !used[j] && guess[i]==tgt[j]: set result[i]=10, used[j] and matched[i].
  - Each guess letter consumes at most one target letter.
  - Then go to COMMIT.
- **COMMIT.** 1 cycle.
  - `score`←result, `score_row`←`row`, and pulse `score_valid`.
  - If all positions are green, go to WIN.
  - Else if `row`==ROWS-1, go to LOSE.
  - Else increment `row`, clear `col`/`guess_word`, and go to ENTRY.
- **WIN/LOSE.** Outputs hold. On `Ack`, go to IDLE; `score`, `row` and `guess_word` hold until the next `Start`.
- `target` is sampled only at `Start`; later changes have no effect during the game.
- `Start` outside IDLE and `Ack` outside WIN/LOSE are ignored.

## Timing
- **Reset.** When `reset`=0 at a rising edge, the next cycle has:
  - state IDLE, so `q_I`=1 and all other flags 0;
  - `row`=0, `col`=0, `guess_word`=0, `score`=0, `score_row`=0, `score_valid`=0;
  - internal `used`/`matched` masks and scan indices cleared.
- Reset mid-scan aborts the scan; no `score_valid` pulse is issued.
- **ENTRY key latency.** A key pulse at edge N is reflected in `col`/`guess_word` after edge N.
- **Scoring latency.** With `enter` accepted at edge N:
  - `q_Green` is 1 for cycles N+1..N+5;
  - `q_Yellow` is 1 for N+6..N+30;
  - `q_Commit` and `score_valid` are 1 at N+31;
  - the next state (ENTRY/WIN/LOSE) is visible at N+32.
- Key inputs are ignored during GREEN/YELLOW/COMMIT and are not queued.
- All outputs are registered, with no combinational paths from inputs to outputs.

## Test plan
- **Basic win.** Reset, then `Start` with target APPLE; type A,P,P,L,E, then `enter`.
  - Expect `score_valid` exactly 31 cycles after `enter`, with `score`=10'h3FF and `score_row`=0.
  - Expect `q_Win` next; then `Ack` → `q_I`.
- **Yellow with duplicates.** Target APPLE, guess PAPER.
  - Expect `score`=10'b01_10_11_10_10 (0x1BA); `row` then goes to 1 and the state to ENTRY.
- **Duplicate gray.** Target APPLE, guess EERIE.
  - Expect positions 0–3 = 01 and position 4 = 11, i.e. `score`=10'h355.
- **Entry edges.**
  - `enter` at `col`=3 is ignored.
  - A 6th letter is ignored (`col` stays 5).
  - `bksp` at `col`=0 is ignored.
  - Same-cycle `letter_en`+`bksp` at `col`=2 gives `col`=1.
  - Letter code 27 is ignored.
- **Lose.** Six non-matching guesses.
  - Expect six `score_valid` pulses with `score_row` 0..5, then `q_Lose`; `Start` is ignored until `Ack`.
- **Reset mid-scan.** Assert `reset`=0 during YELLOW cycle 10.
  - Expect no `score_valid`, all outputs at reset values, and a fresh game on the next `Start`.

Source files
------------

// File: rtl/wordle_guess_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wordle_guess_ctrl
// Purpose  : Sequencing controller for one Wordle game. Collects up to five
//            letters per row, handles backspace/enter, scores a submitted row
//            against the latched target with a fixed-latency two-pass scan
//            (green pass, then yellow pass), and steps through ROWS rows to a
//            WIN or LOSE state that holds until acknowledged.
// Ports    : Clk, reset (sync, active-low)
//            Start, Ack                 - game control pulses
//            target                     - target word, sampled at Start
//            letter_en/letter, bksp, enter - keyboard event pulses
//            guess_word, row, col       - current row contents / position
//            score, score_valid, score_row - result of the last scored row
//            q_I..q_Lose                - one-hot state flags
// Revision : 1.0 - initial release
// ============================================================================
module wordle_guess_ctrl #(
  parameter int ROWS  = 6,
  parameter int LET_W = 5
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               Start,
  input  logic               Ack,
  input  logic [5*LET_W-1:0] target,
  input  logic               letter_en,
  input  logic [LET_W-1:0]   letter,
  input  logic               bksp,
  input  logic               enter,
  output logic [5*LET_W-1:0] guess_word,
  output logic [2:0]         row,
  output logic [2:0]         col,
  output logic [9:0]         score,
  output logic               score_valid,
  output logic [2:0]         score_row,
  output logic               q_I,
  output logic               q_Entry,
  output logic               q_Green,
  output logic               q_Yellow,
  output logic               q_Commit,
  output logic               q_Win,
  output logic               q_Lose
);

  localparam logic [LET_W-1:0] c_MAX_LETTER = LET_W'(25);
  localparam logic [2:0]       c_LAST_ROW   = 3'(ROWS - 1);
  localparam logic [2:0]       c_LAST_IDX   = 3'd4;

  // One-hot encoding so every state flag is a register bit.
  typedef enum logic [6:0] {
    S_IDLE   = 7'b0000001,
    S_ENTRY  = 7'b0000010,
    S_GREEN  = 7'b0000100,
    S_YELLOW = 7'b0001000,
    S_COMMIT = 7'b0010000,
    S_WIN    = 7'b0100000,
    S_LOSE   = 7'b1000000
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [5*LET_W-1:0] r_target, r_guess;
  logic [2:0]         r_row, r_col, r_score_row;
  logic [9:0]         r_score, r_result;
  logic [4:0]         r_used, r_matched;
  logic [2:0]         r_i, r_j;

  logic [LET_W-1:0]   w_guess_let [5];
  logic [LET_W-1:0]   w_tgt_let   [5];
  logic [LET_W-1:0]   w_gi, w_tsel;
  logic               w_hit;
  logic [9:0]         w_result_nxt;
  logic [4:0]         w_used_nxt, w_matched_nxt;

  // Unpack the words into per-position letters for indexed comparison.
  always_comb begin
    for (int p = 0; p < 5; p++) begin
      w_guess_let[p] = r_guess[LET_W*p +: LET_W];
      w_tgt_let[p]   = r_target[LET_W*p +: LET_W];
    end
  end

  // Green pass compares guess[i] with target[i]; yellow pass with target[j].
  assign w_gi   = w_guess_let[r_i];
  assign w_tsel = (r_state == S_GREEN) ? w_tgt_let[r_i] : w_tgt_let[r_j];
  assign w_hit  = (w_gi == w_tsel);

  // One scan step: the result/mask values after the current (i,j) cycle.
  always_comb begin
    w_result_nxt  = r_result;
    w_used_nxt    = r_used;
    w_matched_nxt = r_matched;
    for (int p = 0; p < 5; p++) begin
      if (r_i == 3'(p)) begin
        if (r_state == S_GREEN) begin
          if (w_hit) begin
            w_result_nxt[2*p +: 2] = 2'b11;
            w_used_nxt[p]          = 1'b1;
            w_matched_nxt[p]       = 1'b1;
          end else begin
            w_result_nxt[2*p +: 2] = 2'b01;
          end
        end else if (r_state == S_YELLOW) begin
          // A target letter already consumed (green or earlier yellow)
          // cannot be claimed again, so duplicates score correctly.
          if (!r_matched[p] && !r_used[r_j] && w_hit) begin
            w_result_nxt[2*p +: 2] = 2'b10;
            w_used_nxt[r_j]        = 1'b1;
            w_matched_nxt[p]       = 1'b1;
          end
        end
      end
    end
  end

  // State register
  always_ff @(posedge Clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (Start) w_state_nxt = S_ENTRY;
      S_ENTRY:  if (enter && (r_col == 3'd5)) w_state_nxt = S_GREEN;
      S_GREEN:  if (r_i == c_LAST_IDX) w_state_nxt = S_YELLOW;
      S_YELLOW: if ((r_i == c_LAST_IDX) && (r_j == c_LAST_IDX)) w_state_nxt = S_COMMIT;
      S_COMMIT: begin
        if (r_score == 10'h3FF)        w_state_nxt = S_WIN;
        else if (r_row == c_LAST_ROW)  w_state_nxt = S_LOSE;
        else                           w_state_nxt = S_ENTRY;
      end
      S_WIN, S_LOSE: if (Ack) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge Clk) begin
    if (!reset) begin
      r_target    <= '0;
      r_guess     <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_score     <= '0;
      r_score_row <= '0;
      r_result    <= '0;
      r_used      <= '0;
      r_matched   <= '0;
      r_i         <= '0;
      r_j         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_target <= target;
            r_row    <= '0;
            r_col    <= '0;
            r_guess  <= '0;
            r_score  <= '0;
          end
        end
        S_ENTRY: begin
          // enter > bksp > letter_en; a lower-priority event is dropped
          // even when the higher-priority one is itself ignored.
          if (enter) begin
            if (r_col == 3'd5) begin
              r_i       <= '0;
              r_j       <= '0;
              r_used    <= '0;
              r_matched <= '0;
              r_result  <= '0;
            end
          end else if (bksp) begin
            if (r_col != 3'd0) begin
              r_col <= r_col - 3'd1;
              for (int p = 0; p < 5; p++)
                if (r_col == 3'(p + 1)) r_guess[LET_W*p +: LET_W] <= '0;
            end
          end else if (letter_en && (r_col < 3'd5) && (letter <= c_MAX_LETTER)) begin
            r_col <= r_col + 3'd1;
            for (int p = 0; p < 5; p++)
              if (r_col == 3'(p)) r_guess[LET_W*p +: LET_W] <= letter;
          end
        end
        S_GREEN: begin
          r_result  <= w_result_nxt;
          r_used    <= w_used_nxt;
          r_matched <= w_matched_nxt;
          r_i       <= (r_i == c_LAST_IDX) ? 3'd0 : r_i + 3'd1;
        end
        S_YELLOW: begin
          r_result  <= w_result_nxt;
          r_used    <= w_used_nxt;
          r_matched <= w_matched_nxt;
          if (r_j == c_LAST_IDX) begin
            r_j <= '0;
            if (r_i == c_LAST_IDX) begin
              r_i <= '0;
              // Load the final result on the last scan edge so score is
              // already valid in the COMMIT cycle alongside score_valid.
              r_score     <= w_result_nxt;
              r_score_row <= r_row;
            end else begin
              r_i <= r_i + 3'd1;
            end
          end else begin
            r_j <= r_j + 3'd1;
          end
        end
        S_COMMIT: begin
          if ((r_score != 10'h3FF) && (r_row != c_LAST_ROW)) begin
            r_row   <= r_row + 3'd1;
            r_col   <= '0;
            r_guess <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign guess_word  = r_guess;
  assign row         = r_row;
  assign col         = r_col;
  assign score       = r_score;
  assign score_row   = r_score_row;
  assign q_I         = r_state[0];
  assign q_Entry     = r_state[1];
  assign q_Green     = r_state[2];
  assign q_Yellow    = r_state[3];
  assign q_Commit    = r_state[4];
  assign q_Win       = r_state[5];
  assign q_Lose      = r_state[6];
  assign score_valid = r_state[4];

endmodule
`default_nettype wire

// File: tb/tb_wordle_guess_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wordle_guess_ctrl
// Purpose  : Self-checking bench for wordle_guess_ctrl. Directed entry-edge
//            cases plus randomized guesses, scored by a letter-count Wordle
//            reference model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_wordle_guess_ctrl;

  logic        Clk = 1'b0;
  logic        reset, Start, Ack, letter_en, bksp, enter;
  logic [24:0] target;
  logic [4:0]  letter;
  logic [24:0] guess_word;
  logic [2:0]  row, col, score_row;
  logic [9:0]  score;
  logic        score_valid;
  logic        q_I, q_Entry, q_Green, q_Yellow, q_Commit, q_Win, q_Lose;
  logic [6:0]  flags;

  int n_total = 0;
  int n_pass  = 0;
  logic [2:0] exp_row;

  localparam logic [6:0] F_IDLE   = 7'b0000001;
  localparam logic [6:0] F_ENTRY  = 7'b0000010;
  localparam logic [6:0] F_GREEN  = 7'b0000100;
  localparam logic [6:0] F_YELLOW = 7'b0001000;
  localparam logic [6:0] F_COMMIT = 7'b0010000;
  localparam logic [6:0] F_WIN    = 7'b0100000;
  localparam logic [6:0] F_LOSE   = 7'b1000000;

  always #5 Clk = ~Clk;

  assign flags = {q_Lose, q_Win, q_Commit, q_Yellow, q_Green, q_Entry, q_I};

  wordle_guess_ctrl #(.ROWS(6), .LET_W(5)) dut (
    .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .target(target),
    .letter_en(letter_en), .letter(letter), .bksp(bksp), .enter(enter),
    .guess_word(guess_word), .row(row), .col(col), .score(score),
    .score_valid(score_valid), .score_row(score_row),
    .q_I(q_I), .q_Entry(q_Entry), .q_Green(q_Green), .q_Yellow(q_Yellow),
    .q_Commit(q_Commit), .q_Win(q_Win), .q_Lose(q_Lose)
  );

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [24:0] mk(input string s);
    logic [24:0] w;
    logic [7:0]  ch;
    w = '0;
    for (int p = 0; p < 5; p++) begin
      ch = s[p];
      w[5*p +: 5] = 5'(ch - 8'd65);
    end
    return w;
  endfunction

  // Wordle rule: greens first; then each non-green guess letter takes a
  // yellow if any unconsumed target copy of that letter remains.
  function automatic logic [9:0] ref_score(input logic [24:0] g, input logic [24:0] t);
    logic [9:0] s;
    int         remaining [26];
    logic [4:0] gl, tl;
    logic       green [5];
    s = '0;
    for (int k = 0; k < 26; k++) remaining[k] = 0;
    for (int p = 0; p < 5; p++) begin
      gl = g[5*p +: 5];
      tl = t[5*p +: 5];
      green[p] = (gl == tl);
      if (green[p]) s[2*p +: 2] = 2'b11;
      else          remaining[tl]++;
    end
    for (int p = 0; p < 5; p++) begin
      if (!green[p]) begin
        gl = g[5*p +: 5];
        if (remaining[gl] > 0) begin
          s[2*p +: 2] = 2'b10;
          remaining[gl]--;
        end else begin
          s[2*p +: 2] = 2'b01;
        end
      end
    end
    return s;
  endfunction

  task automatic key_letter(input logic [4:0] l);
    letter = l; letter_en = 1'b1; tick(); letter_en = 1'b0;
  endtask

  task automatic key_bksp();
    bksp = 1'b1; tick(); bksp = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1; tick(); Start = 1'b0;
  endtask

  task automatic pulse_ack();
    Ack = 1'b1; tick(); Ack = 1'b0;
  endtask

  task automatic type_word(input logic [24:0] w);
    for (int p = 0; p < 5; p++) key_letter(w[5*p +: 5]);
  endtask

  task automatic check_reset_state();
    chk("rst_flags", 32'(flags), 32'(F_IDLE));
    chk("rst_row", 32'(row), 32'd0);
    chk("rst_col", 32'(col), 32'd0);
    chk("rst_guess", 32'(guess_word), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_score_row", 32'(score_row), 32'd0);
    chk("rst_score_valid", 32'(score_valid), 32'd0);
  endtask

  // Type a full row, submit it and check latency, score and successor state.
  task automatic submit(input logic [24:0] g, input logic [24:0] t, output logic won);
    logic [9:0] es;
    type_word(g);
    chk("col_full", 32'(col), 32'd5);
    chk("guess_word", 32'(guess_word), 32'(g));
    es = ref_score(g, t);
    enter = 1'b1; tick(); enter = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      if (k == 1 || k == 5)  chk("green_phase", 32'(flags), 32'(F_GREEN));
      if (k == 6 || k == 30) chk("yellow_phase", 32'(flags), 32'(F_YELLOW));
      if (k == 30)           chk("no_early_valid", 32'(score_valid), 32'd0);
      if (k == 31) begin
        chk("commit_flags", 32'(flags), 32'(F_COMMIT));
        chk("score_valid", 32'(score_valid), 32'd1);
        chk("score", 32'(score), 32'(es));
        chk("score_row", 32'(score_row), 32'(exp_row));
      end else begin
        tick();
      end
    end
    tick();
    chk("valid_pulse_end", 32'(score_valid), 32'd0);
    won = (es == 10'h3FF);
    if (won) begin
      chk("win_flags", 32'(flags), 32'(F_WIN));
    end else if (exp_row == 3'd5) begin
      chk("lose_flags", 32'(flags), 32'(F_LOSE));
    end else begin
      exp_row = exp_row + 3'd1;
      chk("next_entry", 32'(flags), 32'(F_ENTRY));
      chk("next_row", 32'(row), 32'(exp_row));
      chk("next_col", 32'(col), 32'd0);
      chk("next_guess", 32'(guess_word), 32'd0);
    end
  endtask

  initial begin
    logic [24:0] apple, tgt, g;
    logic [4:0]  pool [5];
    logic        won;
    int          nvalid;

    pool = '{5'd0, 5'd15, 5'd11, 5'd4, 5'd23};  // A P L E X
    apple = mk("APPLE");
    reset = 1'b0; Start = 1'b0; Ack = 1'b0; letter_en = 1'b0;
    bksp = 1'b0; enter = 1'b0; letter = '0; target = '0;
    tick(); tick();
    reset = 1'b1;
    check_reset_state();

    // ---- Game 1: entry edge cases, then a win ----
    target = apple;
    pulse_start();
    target = mk("ZZZZZ");  // must not affect the running game
    exp_row = 3'd0;
    chk("start_entry", 32'(flags), 32'(F_ENTRY));
    key_letter(5'd0); key_letter(5'd15); key_letter(5'd15);
    chk("col3", 32'(col), 32'd3);
    enter = 1'b1; tick(); enter = 1'b0;
    chk("enter_col3_ignored", 32'(flags), 32'(F_ENTRY));
    chk("enter_col3_col", 32'(col), 32'd3);
    key_bksp(); key_bksp(); key_bksp();
    chk("bksp_to0_guess", 32'(guess_word), 32'd0);
    key_bksp();
    chk("bksp_at0_col", 32'(col), 32'd0);
    key_letter(5'd0); key_letter(5'd15);
    letter = 5'd7; letter_en = 1'b1; bksp = 1'b1; tick();
    letter_en = 1'b0; bksp = 1'b0;
    chk("bksp_wins_col", 32'(col), 32'd1);
    chk("bksp_wins_guess", 32'(guess_word), 32'd0);
    key_letter(5'd27);
    chk("illegal_letter_col", 32'(col), 32'd1);
    key_letter(5'd15); key_letter(5'd15); key_letter(5'd11); key_letter(5'd4);
    key_letter(5'd3);
    chk("sixth_letter_col", 32'(col), 32'd5);
    chk("sixth_letter_guess", 32'(guess_word), 32'(apple));
    key_bksp(); key_bksp(); key_bksp(); key_bksp(); key_bksp();
    submit(apple, apple, won);
    chk("win_score", 32'(score), 32'h3FF);
    pulse_ack();
    chk("ack_idle", 32'(flags), 32'(F_IDLE));
    chk("idle_hold_guess", 32'(guess_word), 32'(apple));
    chk("idle_hold_score", 32'(score), 32'h3FF);

    // ---- Game 2: duplicates, then lose over six rows ----
    target = apple;
    pulse_start();
    exp_row = 3'd0;
    chk("g2_cleared_score", 32'(score), 32'd0);
    submit(mk("PAPER"), apple, won);
    chk("paper_const", 32'(dut.score), 32'h1BA);
    submit(mk("EERIE"), apple, won);
    chk("eerie_const", 32'(score), 32'h355);
    for (int r = 2; r < 6; r++) begin
      g = apple;
      for (int a = 0; a < 20 && g == apple; a++)
        for (int p = 0; p < 5; p++) g[5*p +: 5] = pool[$urandom_range(0, 4)];
      submit(g, apple, won);
    end
    pulse_start();
    chk("start_in_lose_ignored", 32'(flags), 32'(F_LOSE));
    pulse_ack();
    chk("lose_ack_idle", 32'(flags), 32'(F_IDLE));
    chk("lose_hold_row", 32'(row), 32'd5);

    // ---- Game 3: random target/guesses over a 4-letter alphabet ----
    for (int p = 0; p < 5; p++) tgt[5*p +: 5] = 5'($urandom_range(0, 3));
    target = tgt;
    pulse_start();
    exp_row = 3'd0;
    won = 1'b0;
    for (int r = 0; r < 6 && !won; r++) begin
      for (int p = 0; p < 5; p++) g[5*p +: 5] = 5'($urandom_range(0, 3));
      submit(g, tgt, won);
    end
    pulse_ack();
    chk("g3_ack_idle", 32'(flags), 32'(F_IDLE));

    // ---- Game 4: reset during the yellow pass ----
    for (int p = 0; p < 5; p++) tgt[5*p +: 5] = 5'($urandom_range(0, 25));
    target = tgt;
    pulse_start();
    for (int p = 0; p < 5; p++) g[5*p +: 5] = 5'($urandom_range(0, 25));
    type_word(g);
    enter = 1'b1; tick(); enter = 1'b0;
    for (int k = 1; k < 16; k++) tick();
    chk("pre_reset_yellow", 32'(flags), 32'(F_YELLOW));
    reset = 1'b0; tick(); reset = 1'b1;
    check_reset_state();
    nvalid = 0;
    for (int k = 0; k < 40; k++) begin
      if (score_valid) nvalid++;
      tick();
    end
    chk("no_valid_after_abort", 32'(nvalid), 32'd0);
    chk("abort_stays_idle", 32'(flags), 32'(F_IDLE));
    for (int p = 0; p < 5; p++) tgt[5*p +: 5] = 5'($urandom_range(0, 3));
    target = tgt;
    pulse_start();
    exp_row = 3'd0;
    chk("fresh_row", 32'(row), 32'd0);
    for (int p = 0; p < 5; p++) g[5*p +: 5] = 5'($urandom_range(0, 3));
    submit(g, tgt, won);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
